// File: rtl/calc_ascii_pkg.sv
// Package: calc_ascii_pkg
// Shared ASCII constants and the serializer FSM state type. The same constants
// are used by the calculator's digit/operator decode.
// Build option: SERIALIZER_CRLF_EN adds the CR and LF states to ser_state_t.
package calc_ascii_pkg;

    localparam logic [7:0] CH_NUL  = 8'h00;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SEND
`ifdef SERIALIZER_CRLF_EN
        ,
        S_CR,
        S_LF
`endif
    } ser_state_t;

    // Leading padding produced by the calculator is either NUL or space.
    function automatic logic is_blank(input logic [7:0] ch);
        return (ch == CH_NUL) || (ch == CH_SP);
    endfunction

endpackage

// File: rtl/ascii_lead_scan.sv
// Module: ascii_lead_scan
// Combinational priority encoder over a character buffer. Byte NCHARS-1 is the
// first (leftmost) character; idx reports the highest-order byte that is not
// NUL/space, and all_blank is set when no such byte exists (idx is then 0).
// Ports:
//   chars      in   NCHARS x 8   character buffer, chars[NCHARS-1] first
//   idx        out  IDX_W        index of first printable character
//   all_blank  out  1            buffer holds only NUL/space
module ascii_lead_scan
    import calc_ascii_pkg::*;
#(
    parameter int NCHARS = 32,
    parameter int IDX_W  = $clog2(NCHARS)
) (
    input  logic [NCHARS-1:0][7:0] chars,
    output logic [IDX_W-1:0]       idx,
    output logic                   all_blank
);

    logic [NCHARS-1:0] printable;

    generate
        for (genvar gi = 0; gi < NCHARS; gi++) begin : g_flag
            assign printable[gi] = !is_blank(chars[gi]);
        end
    endgenerate

    // Ascending scan: the last hit (highest index) wins.
    always_comb begin
        idx       = '0;
        all_blank = 1'b1;
        for (int i = 0; i < NCHARS; i++) begin
            if (printable[i]) begin
                idx       = IDX_W'(i);
                all_blank = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ascii_result_serializer.sv
// Module: ascii_result_serializer
// Captures the calculator's result string, strips leading NUL/space and
// streams the remaining characters one byte per valid/ready handshake.
// An all-blank result is sent as a single "0".
// Build option: SERIALIZER_CRLF_EN appends CR, LF after the last character.
// Ports:
//   clk          in   1          rising-edge clock
//   rst_n        in   1          asynchronous active-low reset
//   result_in    in   8*NCHARS   result string, top byte is first character
//   result_load  in   1          capture result_in (only when load_ready)
//   load_ready   out  1          idle, ready to accept a new result
//   char_out     out  8          current output character
//   char_valid   out  1          char_out valid
//   char_ready   in   1          downstream accept
//   busy         out  1          not idle
//   done         out  1          one-cycle pulse after the final handshake
module ascii_result_serializer
    import calc_ascii_pkg::*;
#(
    parameter int NCHARS = 32,
    parameter int IDX_W  = $clog2(NCHARS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*NCHARS-1:0]   result_in,
    input  logic                  result_load,
    output logic                  load_ready,
    output logic [7:0]            char_out,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  busy,
    output logic                  done
);

    ser_state_t               state_reg;
    logic [NCHARS-1:0][7:0]   buffer_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic [7:0]               char_out_reg;
    logic                     char_valid_reg;
    logic                     done_reg;

    logic [IDX_W-1:0]         scan_idx;
    logic                     scan_all_blank;
    logic [IDX_W-1:0]         idx_dec;
    logic                     handshake;

    ascii_lead_scan #(
        .NCHARS (NCHARS),
        .IDX_W  (IDX_W)
    ) u_scan (
        .chars     (buffer_reg),
        .idx       (scan_idx),
        .all_blank (scan_all_blank)
    );

    assign idx_dec   = idx_reg - 1'b1;
    assign handshake = char_valid_reg && char_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            buffer_reg     <= '0;
            idx_reg        <= '0;
            char_out_reg   <= CH_NUL;
            char_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (result_load) begin
                        buffer_reg <= result_in;
                        state_reg  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    state_reg      <= S_SEND;
                    char_valid_reg <= 1'b1;
                    // An all-blank result is sent as "0"; idx 0 makes it the
                    // last byte so the normal SEND path finishes after it.
                    if (scan_all_blank) begin
                        idx_reg      <= '0;
                        char_out_reg <= CH_ZERO;
                    end else begin
                        idx_reg      <= scan_idx;
                        char_out_reg <= buffer_reg[scan_idx];
                    end
                end
                S_SEND: begin
                    if (handshake) begin
                        if (idx_reg == '0) begin
`ifdef SERIALIZER_CRLF_EN
                            state_reg    <= S_CR;
                            char_out_reg <= CH_CR;
`else
                            state_reg      <= S_IDLE;
                            char_valid_reg <= 1'b0;
                            done_reg       <= 1'b1;
`endif
                        end else begin
                            // Preload the next byte so there is no bubble.
                            idx_reg      <= idx_dec;
                            char_out_reg <= buffer_reg[idx_dec];
                        end
                    end
                end
`ifdef SERIALIZER_CRLF_EN
                S_CR: begin
                    if (handshake) begin
                        state_reg    <= S_LF;
                        char_out_reg <= CH_LF;
                    end
                end
                S_LF: begin
                    if (handshake) begin
                        state_reg      <= S_IDLE;
                        char_valid_reg <= 1'b0;
                        done_reg       <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_reg      <= S_IDLE;
                    char_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign char_out   = char_out_reg;
    assign char_valid = char_valid_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_ascii_result_serializer.sv
// Testbench: tb_ascii_result_serializer
// Directed stimulus for ascii_result_serializer; honours SERIALIZER_CRLF_EN.
module tb_ascii_result_serializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] result_in = '0;
    logic         result_load = 1'b0;
    logic         load_ready;
    logic [7:0]   char_out;
    logic         char_valid;
    logic         char_ready = 1'b0;
    logic         busy;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    // Expected stream for the collector
    logic [7:0] exp_bytes [16];
    int         exp_n = 0;
    int         exp_done_cyc = 0;
    logic [31:0] rdy_pat = 32'hFFFF_FFFF;
    int         inject_at = -1;

    ascii_result_serializer #(.NCHARS(32), .IDX_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .result_in   (result_in),
        .result_load (result_load),
        .load_ready  (load_ready),
        .char_out    (char_out),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n bytes in b (first byte most significant); done_cyc assumes no CRLF.
    task automatic set_exp(input int n, input logic [63:0] b, input int done_cyc);
        for (int i = 0; i < n; i++) exp_bytes[i] = b[8*(n-1-i) +: 8];
        exp_n        = n;
        exp_done_cyc = done_cyc;
`ifdef SERIALIZER_CRLF_EN
        exp_bytes[n]   = 8'h0D;
        exp_bytes[n+1] = 8'h0A;
        exp_n          = n + 2;
        exp_done_cyc   = done_cyc + 2;
`endif
    endtask

    // Called at a negedge; the load is taken on the next posedge.
    task automatic load(input logic [255:0] d);
        result_in   = d;
        result_load = 1'b1;
        @(negedge clk);
        result_load = 1'b0;
    endtask

    // Starts at the negedge right after the load edge; ends on the done negedge.
    task automatic collect(input string tag);
        int   got = 0;
        int   cyc = 0;
        bit   seen = 0;
        bit   prev_stall = 0;
        logic [7:0] prev_out = '0;
        while (!seen && cyc < 200) begin
            char_ready  = (cyc < 32) ? rdy_pat[cyc] : 1'b1;
            result_load = (cyc == inject_at);
            if (cyc == inject_at) result_in = 256'h3939;
            if (prev_stall) begin
                chk({tag, " stall_hold"}, {24'd0, char_out}, {24'd0, prev_out});
                chk({tag, " stall_valid"}, {31'd0, char_valid}, 32'd1);
            end
            if (cyc == 1) begin
                chk({tag, " busy"}, {31'd0, busy}, 32'd1);
                chk({tag, " load_ready_busy"}, {31'd0, load_ready}, 32'd0);
            end
            if (char_valid && char_ready) begin
                if (got < exp_n)
                    chk($sformatf("%s byte%0d", tag, got), {24'd0, char_out}, {24'd0, exp_bytes[got]});
                else
                    chk({tag, " extra_byte"}, got, exp_n);
                $display("%s: byte %0d = %02h", tag, got, char_out);
                got++;
            end
            prev_stall = char_valid && !char_ready;
            prev_out   = char_out;
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1;
                chk({tag, " done_cycle"}, cyc, exp_done_cyc);
                chk({tag, " byte_count"}, got, exp_n);
                chk({tag, " load_ready_end"}, {31'd0, load_ready}, 32'd1);
                chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
                chk({tag, " valid_end"}, {31'd0, char_valid}, 32'd0);
            end
        end
        if (!seen) chk({tag, " timeout"}, {31'd0, seen}, 32'd1);
        result_load = 1'b0;
        char_ready  = 1'b1;
        rdy_pat     = 32'hFFFF_FFFF;
        inject_at   = -1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst char_out", {24'd0, char_out}, 32'd0);
        chk("rst char_valid", {31'd0, char_valid}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        char_ready = 1'b1;
        @(negedge clk);

        // 1: 30 NULs + "42", full ready
        load(256'h3432);
        chk("t1 scan_no_valid", {31'd0, char_valid}, 32'd0);
        set_exp(2, 64'h3432, 3);
        collect("t1");

        // 2: reloaded on the done cycle; ready pattern 1,0,0,1
        load(256'h3432);
        chk("t2 done_pulse_width", {31'd0, done}, 32'd0);
        chk("t2 load_on_done", {31'd0, busy}, 32'd1);
        rdy_pat = 32'hFFFF_FFF9;
        set_exp(2, 64'h3432, 5);
        collect("t2");

        // 3: all-zero buffer sends "0"
        load(256'h0);
        set_exp(1, 64'h30, 2);
        collect("t3");

        // 4: 28 spaces + "-12 ", trailing space kept
        load({{28{8'h20}}, 32'h2D31_3220});
        set_exp(4, 64'h2D31_3220, 5);
        collect("t4");

        // 5: load attempt while streaming is ignored
        load(256'h3432);
        inject_at = 1;
        set_exp(2, 64'h3432, 3);
        collect("t5");

        // 6: async reset mid-stream, then fresh load
        load({{28{8'h20}}, 32'h2D31_3220});
        repeat (2) @(negedge clk);
        chk("t6 streaming", {31'd0, char_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst_valid", {31'd0, char_valid}, 32'd0);
        chk("t6 rst_busy", {31'd0, busy}, 32'd0);
        chk("t6 rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("t6 rst_char_out", {24'd0, char_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load(256'h3432);
        set_exp(2, 64'h3432, 3);
        collect("t6");

        @(negedge clk);
        chk("end idle", {31'd0, load_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
